qspi_ram_slave: RTL and testbench



---
 rtl/qspi_ram_slave.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_qspi_ram_slave.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_ram_slave.sv
// -----------------------------------------------------------------------------
// qspi_ram_slave
//
// Quad-SPI slave (SPI mode 0) that gives the ESP32 host access to the shared
// byte RAM. The same RAM also holds the FPU sequencer's operands and results.
// Every QSPI input is oversampled through 2-flop synchronisers into clk. All
// decoding is done on the resulting single-clk sck/cs_n edge pulses.
//
// Transaction format (all phases quad, high nibble first):
//   opcode (2 nibbles) | address (addr_width/4 nibbles) |
//   write: data bytes ...
//   read : dummy_cycles SCKs, then data bytes ...
//
// Ports:
//   clk, rst       system clock (>= 8x SCK), synchronous active-high reset
//   qspi_sck       QSPI serial clock, idle low
//   qspi_cs_n      chip select, active low
//   qspi_io_in     IO[3:0] from master, IO3 = nibble MSB
//   qspi_io_out    IO[3:0] to master
//   qspi_io_oe     output enable for IO[3:0], high only while returning data
//   addr           RAM address (also the read prefetch address)
//   data_out       RAM write data
//   wen            RAM write enable, single-clk pulse
//   data_in        RAM read data, valid 1 clk after addr is sampled
//   busy           high while the synchronised chip select is asserted
// -----------------------------------------------------------------------------
module qspi_ram_slave #(
    parameter int         addr_width   = 8,
    parameter int         dummy_cycles = 4,
    parameter logic [7:0] cmd_write    = 8'h32,
    parameter logic [7:0] cmd_read     = 8'h6B
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  qspi_sck,
    input  logic                  qspi_cs_n,
    input  logic [3:0]            qspi_io_in,
    output logic [3:0]            qspi_io_out,
    output logic                  qspi_io_oe,
    output logic [addr_width-1:0] addr,
    output logic [7:0]            data_out,
    output logic                  wen,
    input  logic [7:0]            data_in,
    output logic                  busy
);

    localparam int ADDR_NIBBLES = addr_width / 4;
    localparam int ADDR_LAST    = ADDR_NIBBLES - 1;
    localparam int DUMMY_LAST   = (dummy_cycles > 0) ? dummy_cycles - 1 : 0;
    localparam int CNT_MAX_A    = (ADDR_NIBBLES > dummy_cycles) ? ADDR_NIBBLES : dummy_cycles;
    localparam int CNT_MAX      = (CNT_MAX_A > 2) ? CNT_MAX_A : 2;
    localparam int CNT_W        = $clog2(CNT_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_WDATA,
        S_RDATA,
        S_IGNORE
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers. The io bus goes through the same number of
    // stages as sck, so the nibble seen on a sck_rise pulse is the one
    // the master set up before that edge.
    // ------------------------------------------------------------------
    logic       r_sck_meta, r_sck_sync, r_sck_prev;
    logic       r_cs_meta,  r_cs_sync,  r_cs_prev;
    logic [3:0] r_io_meta,  r_io_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sck_meta <= 1'b0;
            r_sck_sync <= 1'b0;
            r_sck_prev <= 1'b0;
            r_cs_meta  <= 1'b0;
            r_cs_sync  <= 1'b0;
            r_cs_prev  <= 1'b0;
            r_io_meta  <= 4'h0;
            r_io_sync  <= 4'h0;
        end else begin
            r_sck_meta <= qspi_sck;
            r_sck_sync <= r_sck_meta;
            r_sck_prev <= r_sck_sync;
            r_cs_meta  <= qspi_cs_n;
            r_cs_sync  <= r_cs_meta;
            r_cs_prev  <= r_cs_sync;
            r_io_meta  <= qspi_io_in;
            r_io_sync  <= r_io_meta;
        end
    end

    // Chip-select flops come out of reset low. If cs_n is idle high this
    // only produces one harmless rise; if cs_n is held low through reset
    // no fall is seen, so an interrupted transaction stays abandoned.
    logic w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;
    assign w_sck_rise = r_sck_sync & ~r_sck_prev;
    assign w_sck_fall = ~r_sck_sync & r_sck_prev;
    assign w_cs_fall  = ~r_cs_sync & r_cs_prev;
    assign w_cs_rise  = r_cs_sync & ~r_cs_prev;

    // ------------------------------------------------------------------
    // Protocol FSM and datapath
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [3:0]            r_cmd_hi;
    logic                  r_is_read;
    logic [addr_width-1:0] r_addr_shift;
    logic [3:0]            r_wr_hi;
    logic                  r_nib;         // 0: expecting/driving high nibble
    logic                  r_first_fall;  // SCK fall that closes the last pre-data rise
    logic [3:0]            r_tx_lo;       // low nibble of the byte being sent
    logic [7:0]            r_prefetch;
    logic [1:0]            r_pf_dly;      // addr-change to data_in-valid delay line
    logic                  r_load_first;  // zero-dummy read: first byte comes from prefetch
    logic [addr_width-1:0] r_addr;
    logic [7:0]            r_data_out;
    logic                  r_wen;
    logic [3:0]            r_io_out;
    logic                  r_io_oe;
    logic                  r_busy;

    logic [7:0]            w_opcode;
    logic [addr_width-1:0] w_addr_full;

    assign w_opcode    = {r_cmd_hi, r_io_sync};
    assign w_addr_full = (r_addr_shift << 4) | addr_width'(r_io_sync);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_cmd_hi     <= 4'h0;
            r_is_read    <= 1'b0;
            r_addr_shift <= '0;
            r_wr_hi      <= 4'h0;
            r_nib        <= 1'b0;
            r_first_fall <= 1'b0;
            r_tx_lo      <= 4'h0;
            r_prefetch   <= 8'h00;
            r_pf_dly     <= 2'b00;
            r_load_first <= 1'b0;
            r_addr       <= '0;
            r_data_out   <= 8'h00;
            r_wen        <= 1'b0;
            r_io_out     <= 4'h0;
            r_io_oe      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_wen    <= 1'b0;
            r_pf_dly <= {r_pf_dly[0], 1'b0};

            // Post-write address increment, the clk after the wen pulse.
            if (r_wen) begin
                r_addr <= r_addr + addr_width'(1);
            end

            // data_in reflects the new addr two clk edges after addr moved.
            if (r_pf_dly[1]) begin
                r_prefetch <= data_in;
                if (r_load_first) begin
                    r_tx_lo      <= data_in[3:0];
                    r_io_out     <= data_in[7:4];
                    r_load_first <= 1'b0;
                end
            end

            if (w_cs_fall) begin
                r_busy <= 1'b1;
            end

            if (w_cs_rise) begin
                // End of transaction wins over any sck edge this clk; a
                // half-received write byte is simply dropped.
                r_state      <= S_IDLE;
                r_io_oe      <= 1'b0;
                r_io_out     <= 4'h0;
                r_busy       <= 1'b0;
                r_cnt        <= '0;
                r_nib        <= 1'b0;
                r_load_first <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_cs_fall) begin
                            r_state <= S_CMD;
                            r_cnt   <= '0;
                            r_nib   <= 1'b0;
                        end
                    end

                    S_CMD: begin
                        if (w_sck_rise) begin
                            if (r_cnt == '0) begin
                                r_cmd_hi <= r_io_sync;
                                r_cnt    <= CNT_W'(1);
                            end else begin
                                r_cnt <= '0;
                                if (w_opcode == cmd_write) begin
                                    r_is_read <= 1'b0;
                                    r_state   <= S_ADDR;
                                end else if (w_opcode == cmd_read) begin
                                    r_is_read <= 1'b1;
                                    r_state   <= S_ADDR;
                                end else begin
                                    r_state <= S_IGNORE;
                                end
                            end
                        end
                    end

                    S_ADDR: begin
                        if (w_sck_rise) begin
                            r_addr_shift <= w_addr_full;
                            if (r_cnt == CNT_W'(ADDR_LAST)) begin
                                r_cnt  <= '0;
                                r_addr <= w_addr_full;   // read prefetch starts here
                                r_nib  <= 1'b0;
                                if (!r_is_read) begin
                                    r_state <= S_WDATA;
                                end else if (dummy_cycles > 0) begin
                                    r_state <= S_DUMMY;
                                end else begin
                                    r_state      <= S_RDATA;
                                    r_io_oe      <= 1'b1;
                                    r_first_fall <= 1'b1;
                                    r_load_first <= 1'b1;
                                    r_pf_dly     <= 2'b01;
                                end
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                    end

                    S_DUMMY: begin
                        if (w_sck_rise) begin
                            if (r_cnt == CNT_W'(DUMMY_LAST)) begin
                                // The prefetched byte has long been valid.
                                r_cnt        <= '0;
                                r_state      <= S_RDATA;
                                r_io_oe      <= 1'b1;
                                r_tx_lo      <= data_in[3:0];
                                r_io_out     <= data_in[7:4];
                                r_nib        <= 1'b0;
                                r_first_fall <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                    end

                    S_WDATA: begin
                        if (w_sck_rise) begin
                            if (!r_nib) begin
                                r_wr_hi <= r_io_sync;
                                r_nib   <= 1'b1;
                            end else begin
                                r_data_out <= {r_wr_hi, r_io_sync};
                                r_wen      <= 1'b1;
                                r_nib      <= 1'b0;
                            end
                        end
                    end

                    S_RDATA: begin
                        if (w_sck_fall) begin
                            if (r_first_fall) begin
                                // This fall precedes the master's first data
                                // sample, so the high nibble stays on the bus.
                                r_first_fall <= 1'b0;
                            end else if (!r_nib) begin
                                r_io_out <= r_tx_lo;
                                r_nib    <= 1'b1;
                                r_addr   <= r_addr + addr_width'(1);
                                r_pf_dly <= 2'b01;
                            end else begin
                                r_tx_lo  <= r_prefetch[3:0];
                                r_io_out <= r_prefetch[7:4];
                                r_nib    <= 1'b0;
                            end
                        end
                    end

                    S_IGNORE: begin
                        // Unknown opcode: stay off the bus and the RAM.
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign qspi_io_out = r_io_out;
    assign qspi_io_oe  = r_io_oe;
    assign addr        = r_addr;
    assign data_out    = r_data_out;
    assign wen         = r_wen;
    assign busy        = r_busy;

endmodule

// File: tb/tb_qspi_ram_slave.sv
// -----------------------------------------------------------------------------
// Self-checking bench for qspi_ram_slave. Stimulus tasks push expected RAM
// writes and expected read nibbles into queues; independent monitors pop and
// compare whenever the DUT pulses wen or the master samples IO on an SCK rise.
// -----------------------------------------------------------------------------
module tb_qspi_ram_slave;

    localparam int HP = 6;   // SCK half-period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       qspi_sck = 1'b0;
    logic       qspi_cs_n = 1'b1;
    logic [3:0] qspi_io_in = 4'h0;
    logic [3:0] qspi_io_out;
    logic       qspi_io_oe;
    logic [7:0] addr;
    logic [7:0] data_out;
    logic       wen;
    logic [7:0] data_in;
    logic       busy;

    always #5 clk = ~clk;

    qspi_ram_slave #(
        .addr_width  (8),
        .dummy_cycles(4),
        .cmd_write   (8'h32),
        .cmd_read    (8'h6B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .qspi_sck   (qspi_sck),
        .qspi_cs_n  (qspi_cs_n),
        .qspi_io_in (qspi_io_in),
        .qspi_io_out(qspi_io_out),
        .qspi_io_oe (qspi_io_oe),
        .addr       (addr),
        .data_out   (data_out),
        .wen        (wen),
        .data_in    (data_in),
        .busy       (busy)
    );

    // Registered RAM attached to the DUT; preloaded through the init port.
    logic [7:0] tb_ram [256];
    logic       init_we = 1'b0;
    logic [7:0] init_idx = 8'h00;
    logic [7:0] init_data = 8'h00;

    always @(posedge clk) begin
        data_in <= tb_ram[addr];
        if (init_we) tb_ram[init_idx] <= init_data;
        else if (wen) tb_ram[addr] <= data_out;
    end

    // Reference model: what RAM must contain according to the transactions issued.
    logic [7:0]  model_mem [256];
    logic [15:0] exp_wr [$];   // {addr, data}
    logic [3:0]  exp_rd [$];
    logic        tb_expect_oe = 1'b0;
    logic [7:0]  wbuf [8];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Write monitor
    always @(negedge clk) begin
        if (wen) begin
            if (exp_wr.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL unexpected_wen: got addr %0h data %0h, expected no write", addr, data_out);
            end else begin
                logic [15:0] e;
                e = exp_wr.pop_front();
                check("wen_addr", 32'(addr), 32'(e[15:8]));
                check("wen_data", 32'(data_out), 32'(e[7:0]));
            end
        end
    end

    // Read monitor: the master samples IO on every SCK rise.
    always @(posedge qspi_sck) begin
        check("io_oe", 32'(qspi_io_oe), 32'(tb_expect_oe));
        if (tb_expect_oe) begin
            if (exp_rd.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL rd_extra: got nibble %0h, expected none", qspi_io_out);
            end else begin
                logic [3:0] e;
                e = exp_rd.pop_front();
                check("rd_nibble", 32'(qspi_io_out), 32'(e));
            end
        end
    end

    task automatic send_nib(input logic [3:0] n);
        @(negedge clk);
        qspi_io_in = n;
        repeat (HP - 1) @(negedge clk);
        qspi_sck = 1'b1;
        repeat (HP) @(negedge clk);
        qspi_sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_nib(b[7:4]);
        send_nib(b[3:0]);
    endtask

    task automatic cs_begin();
        @(negedge clk);
        qspi_cs_n = 1'b0;
        repeat (HP) @(negedge clk);
        check("busy_active", 32'(busy), 32'd1);
    endtask

    task automatic cs_end();
        repeat (HP) @(negedge clk);
        qspi_cs_n = 1'b1;
        repeat (HP) @(negedge clk);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic do_write(input logic [7:0] a, input int n, input bit extra);
        cs_begin();
        send_byte(8'h32);
        send_byte(a);
        for (int i = 0; i < n; i++) begin
            logic [7:0] wa;
            wa = a + 8'(i);
            exp_wr.push_back({wa, wbuf[i]});
            model_mem[wa] = wbuf[i];
            send_byte(wbuf[i]);
        end
        if (extra) send_nib(4'($urandom_range(0, 15)));
        cs_end();
        $display("[TB] write addr=%02h bytes=%0d partial_nibble=%0d", a, n, extra);
    endtask

    task automatic do_read(input logic [7:0] a, input int n, input int abort_nibs);
        int total;
        total = (abort_nibs > 0) ? abort_nibs : 2 * n;
        cs_begin();
        send_byte(8'h6B);
        send_byte(a);
        for (int i = 0; i < 4; i++) send_nib(4'($urandom_range(0, 15)));
        for (int k = 0; k < total; k++) begin
            logic [7:0] b;
            b = model_mem[a + 8'(k / 2)];
            exp_rd.push_back((k % 2 == 0) ? b[7:4] : b[3:0]);
        end
        tb_expect_oe = 1'b1;
        for (int k = 0; k < total; k++) send_nib(4'($urandom_range(0, 15)));
        if (abort_nibs > 0) begin
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            tb_expect_oe = 1'b0;
            check("rst_io_oe", 32'(qspi_io_oe), 32'd0);
            check("rst_addr", 32'(addr), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            repeat (HP) @(negedge clk);
            qspi_cs_n = 1'b1;
            repeat (HP) @(negedge clk);
            $display("[TB] read addr=%02h aborted by reset after %0d nibbles", a, abort_nibs);
        end else begin
            tb_expect_oe = 1'b0;
            cs_end();
            $display("[TB] read addr=%02h bytes=%0d", a, n);
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Preload RAM and model while reset is held.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'($urandom_range(0, 255));
            if (i == 8'h10) v = 8'h3F;
            if (i == 8'h11) v = 8'h80;
            @(negedge clk);
            init_we   = 1'b1;
            init_idx  = 8'(i);
            init_data = v;
            model_mem[i] = v;
        end
        @(negedge clk);
        init_we = 1'b0;
        check("reset_io_out", 32'(qspi_io_out), 32'd0);
        check("reset_io_oe", 32'(qspi_io_oe), 32'd0);
        check("reset_addr", 32'(addr), 32'd0);
        check("reset_data_out", 32'(data_out), 32'd0);
        check("reset_wen", 32'(wen), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Three-byte write starting at 0x05.
        wbuf[0] = 8'h12; wbuf[1] = 8'h34; wbuf[2] = 8'hAB;
        do_write(8'h05, 3, 1'b0);
        check("final_addr", 32'(addr), 32'h08);

        // Read of preloaded 0x10/0x11 -> nibbles 3,F,8,0.
        do_read(8'h10, 2, 0);

        // Address wrap on write and read.
        wbuf[0] = 8'hAA; wbuf[1] = 8'hBB;
        do_write(8'hFF, 2, 1'b0);
        do_read(8'hFF, 2, 0);

        // Unknown opcode: no RAM access, IO never enabled.
        cs_begin();
        send_byte(8'h9F);
        for (int i = 0; i < 6; i++) send_nib(4'($urandom_range(0, 15)));
        cs_end();
        $display("[TB] bad opcode 9F with 6 nibbles");

        // Partial byte discarded; following transaction decodes normally.
        wbuf[0] = 8'hC5;
        do_write(8'h20, 1, 1'b1);
        do_read(8'h20, 1, 0);

        // Reset in the middle of read data, then a clean read.
        do_read(8'h10, 2, 3);
        repeat (10) @(negedge clk);
        do_read(8'h10, 1, 0);

        // Randomised traffic.
        for (int t = 0; t < 24; t++) begin
            logic [7:0] a;
            int n;
            a = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom_range(0, 255));
                do_write(a, n, ($urandom_range(0, 3) == 0));
            end else begin
                do_read(a, n, 0);
            end
        end

        repeat (10) @(negedge clk);
        check("pending_writes", 32'(exp_wr.size()), 32'd0);
        check("pending_reads", 32'(exp_rd.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
